// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous clock (meas_in) in clk_in cycles,
// flags a stuck/slow input as timeout and reports lock after the first full measurement.
module clock_period_meter #(
  parameter int CNT_WIDTH = 28,
  parameter int TIMEOUT   = 50000000
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 meas_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 valid_out,
  output logic                 timeout_out,
  output logic                 locked_out,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state;
  logic                 s1, s2, s3;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] high_cap;
  logic                 rise, fall;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign dbg_state = state;

  // valid_out is a one-cycle strobe with no back-pressure: period_out/high_out
  // change only in the cycle valid_out is high, and a consumer must capture then.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      high_cap    <= '0;
      period_out  <= '0;
      high_out    <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      s1        <= meas_in;
      s2        <= s1;
      s3        <= s2;
      valid_out <= 1'b0;

      if (!enable) begin
        state      <= IDLE;
        cnt        <= '0;
        locked_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end

          // The first rise only starts the count; it closes no period.
          ARM: begin
            if (cnt >= TIMEOUT_C) begin
              timeout_out <= 1'b1;
              cnt         <= '0;
            end else if (rise) begin
              cnt      <= CNT_ONE;
              high_cap <= '0;
              state    <= MEASURE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          MEASURE: begin
            if (cnt >= TIMEOUT_C) begin
              timeout_out <= 1'b1;
              locked_out  <= 1'b0;
              cnt         <= '0;
              state       <= ARM;
            end else if (rise) begin
              period_out  <= cnt;
              high_out    <= high_cap;
              valid_out   <= 1'b1;
              cnt         <= CNT_ONE;
              high_cap    <= '0;
              timeout_out <= 1'b0;
              locked_out  <= 1'b1;
            end else begin
              if (fall) high_cap <= cnt;
              if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized bench for clock_period_meter: waveform driver, measurement scoreboard
// computed from driven high/low lengths, directed enable/timeout/reset/async scenarios.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int CW = 16;
  localparam int TO = 100;
  localparam int W  = 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          meas_in;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          valid_out;
  logic          timeout_out;
  logic          locked_out;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // scoreboard: {period, high} per completed period, oldest first
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_e;
  bit           have_prev;
  int           last_p, last_h;
  int           epoch;
  int           seen_epoch;
  bit           have_last;
  int           last_valid_cyc;
  logic         prev_v;
  bit           async_mode;
  int           async_cnt;

  clock_period_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .meas_in     (meas_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .valid_out   (valid_out),
    .timeout_out (timeout_out),
    .locked_out  (locked_out),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One meas_in period starting with its rising edge; called on a negedge.
  // Each rise closes the previous period, so the previous shape becomes expected.
  task automatic drive_wave(input int h, input int l, input bit meas);
    if (meas && have_prev) begin
      exp_q.push_back(prev_e);
      last_p = int'(prev_e[W-1:CW]);
      last_h = int'(prev_e[CW-1:0]);
    end
    have_prev = meas;
    prev_e    = {CW'(h + l), CW'(h)};
    meas_in = 1'b1;
    repeat (h) @(negedge clk);
    meas_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic restart();
    have_prev = 1'b0;
    epoch++;
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out) begin
        check("valid_gap", 32'(prev_v), 0);
        check("locked_at_valid", 32'(locked_out), 1);
        check("timeout_at_valid", 32'(timeout_out), 0);
        if (async_mode) begin
          async_cnt++;
          check("async_period", 32'(period_out == 10 || period_out == 11), 1);
          check("async_high", 32'(high_out == 5 || high_out == 6), 1);
        end else begin
          check("exp_avail", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("period", 32'(period_out), 32'(e[W-1:CW]));
            check("high", 32'(high_out), 32'(e[CW-1:0]));
            if (have_last && seen_epoch == epoch)
              check("valid_spacing", cyc - last_valid_cyc, 32'(e[W-1:CW]));
          end
        end
        have_last      = 1'b1;
        seen_epoch     = epoch;
        last_valid_cyc = cyc;
      end
      prev_v = valid_out;
    end
  endtask

  initial begin
    int h, l;
    bit seen;
    rst_n      = 1'b0;
    enable     = 1'b0;
    meas_in    = 1'b0;
    have_prev  = 1'b0;
    epoch      = 0;
    seen_epoch = 0;
    have_last  = 1'b0;
    prev_v     = 1'b0;
    async_mode = 1'b0;
    async_cnt  = 0;
    prev_e     = '0;
    last_p     = 0;
    last_h     = 0;
    last_valid_cyc = 0;

    fork
      monitor();
      begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset values
    repeat (3) @(negedge clk);
    check("rst_period", 32'(period_out), 0);
    check("rst_high", 32'(high_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_timeout", 32'(timeout_out), 0);
    check("rst_locked", 32'(locked_out), 0);
    check("rst_state_idle", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_locked", 32'(locked_out), 0);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // high 3 / low 5: lock only after the second rise
    drive_wave(3, 5, 1);
    check("not_locked_first_rise", 32'(locked_out), 0);
    repeat (5) drive_wave(3, 5, 1);
    check("locked_3_5", 32'(locked_out), 1);

    // minimum period
    repeat (10) drive_wave(1, 1, 1);

    // random shapes
    repeat (40) begin
      h = int'($urandom_range(20, 1));
      l = int'($urandom_range(20, 1));
      drive_wave(h, l, 1);
    end

    // enable dropped for >= 20 cycles while meas_in keeps running
    repeat (2) drive_wave(4, 4, 1);
    enable = 1'b0;
    restart();
    repeat (3) drive_wave(3, 4, 0);
    check("dis_locked", 32'(locked_out), 0);
    check("dis_period_hold", 32'(period_out), 32'(last_p));
    check("dis_high_hold", 32'(high_out), 32'(last_h));
    check("dis_timeout_hold", 32'(timeout_out), 0);
    enable = 1'b1;
    drive_wave(3, 4, 1);
    check("reen_period_hold", 32'(period_out), 32'(last_p));
    check("reen_locked", 32'(locked_out), 0);
    repeat (3) drive_wave(3, 4, 1);

    // timeout: meas_in stuck low after lock
    drive_wave(4, 4, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (timeout_out) seen = 1'b1;
      else @(negedge clk);
    end
    check("timeout_seen", 32'(seen), 1);
    check("timeout_delay", cyc - last_valid_cyc, TO);
    check("timeout_unlocked", 32'(locked_out), 0);
    restart();
    drive_wave(5, 5, 1);
    check("timeout_hold_first_rise", 32'(timeout_out), 1);
    repeat (3) drive_wave(5, 5, 1);
    check("relock_after_timeout", 32'(locked_out), 1);

    // asynchronous reset pulse in the middle of a period
    drive_wave(4, 4, 1);
    repeat (5) @(negedge clk);
    check("exp_q_empty_before_reset", exp_q.size(), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_period", 32'(period_out), 0);
    check("arst_high", 32'(high_out), 0);
    check("arst_valid", 32'(valid_out), 0);
    check("arst_timeout", 32'(timeout_out), 0);
    check("arst_locked", 32'(locked_out), 0);
    restart();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    drive_wave(6, 4, 1);
    check("arst_no_valid_first_rise", 32'(locked_out), 0);
    repeat (3) drive_wave(6, 4, 1);

    // asynchronous meas_in, period 10.3 clk_in cycles, 1000 periods
    drive_wave(4, 4, 1);
    enable = 1'b0;
    restart();
    repeat (5) @(negedge clk);
    enable     = 1'b1;
    async_mode = 1'b1;
    #0.25;
    for (int i = 0; i < 2000; i++) begin
      meas_in = ~meas_in;
      #51.5;
    end
    repeat (6) @(negedge clk);
    async_mode = 1'b0;
    check("async_valid_count", async_cnt, 999);
    check("async_no_timeout", 32'(timeout_out), 0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
